// File: rtl/alu_sequencer.sv
// Sequences single ALU operations: accepts a request, drives an external ALU for one
// cycle, then holds the captured result and error flag until the consumer takes it.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [3:0]  alu_aluc,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cy_in,
    input  logic [15:0] alu_z,
    input  logic        alu_cy,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_z,
    output logic        rsp_err,
    output logic        carry_flag,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never depends on ready, and the payload is held while valid & !ready.

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_CLC = 4'b1011;
    localparam logic [3:0] OP_STC = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [15:0] a_q, b_q;
    logic        accept;

    assign accept    = req_valid & req_ready;
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_aluc  = 4'b0000;
        alu_a     = 16'h0000;
        alu_b     = 16'h0000;
        alu_cy_in = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                alu_aluc  = op_q;
                alu_a     = a_q;
                alu_b     = b_q;
                alu_cy_in = (op_q == OP_ADC) ? carry_flag : 1'b0;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                // A completing response frees the slot for a request in the same cycle.
                req_ready = rsp_ready;
                if (rsp_ready) state_nxt = req_valid ? ISSUE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 4'b0000;
            a_q  <= 16'h0000;
            b_q  <= 16'h0000;
        end else if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    // Result and flag capture happens only on the edge that ends ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_z      <= 16'h0000;
            rsp_err    <= 1'b0;
            carry_flag <= 1'b0;
        end else if (state == ISSUE) begin
            if (op_q <= 4'b1010) begin
                rsp_z   <= alu_z;
                rsp_err <= 1'b0;
                if (op_q == OP_ADD || op_q == OP_ADC) carry_flag <= alu_cy;
            end else if (op_q == OP_CLC) begin
                rsp_err    <= 1'b0;
                carry_flag <= 1'b0;
            end else if (op_q == OP_STC) begin
                rsp_err    <= 1'b0;
                carry_flag <= 1'b1;
            end else begin
                rsp_z   <= 16'h0000;
                rsp_err <= 1'b1;
            end
        end
    end

endmodule
